// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one registered-operand ALU among NREQ requesters.
// Contains the alu it drives; one transaction (IDLE -> EXEC -> RESP) in flight at a time.

module alu #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   af,
  input  logic         i,
  output logic [N-1:0] res,
  output logic         ovf
);
  localparam int SHW = $clog2(N);

  logic [N-1:0]   imm_s;
  logic [N-1:0]   imm_z;
  logic [N-1:0]   op_b;
  logic [N-1:0]   sum;
  logic [N-1:0]   diff;
  logic [SHW-1:0] shamt;

  // Immediate mode takes b[15:0]: sign-extended for arithmetic/compare, zero-extended for logic ops.
  assign imm_s = {{(N-16){b[15]}}, b[15:0]};
  assign imm_z = {{(N-16){1'b0}}, b[15:0]};
  assign op_b  = i ? (af[2] ? imm_z : imm_s) : b;
  assign sum   = a + op_b;
  assign diff  = a - op_b;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (af)
      4'b0000: begin
        res = sum;
        ovf = (a[N-1] == op_b[N-1]) && (sum[N-1] != a[N-1]);
      end
      4'b0001: res = sum;
      4'b0010: begin
        res = diff;
        ovf = (a[N-1] != op_b[N-1]) && (diff[N-1] != a[N-1]);
      end
      4'b0011: res = diff;
      4'b0100: res = a & op_b;
      4'b0101: res = a | op_b;
      4'b0110: res = a ^ op_b;
      4'b0111: res = i ? {b[15:0], {(N-16){1'b0}}} : ~(a | op_b);
      4'b1000: res = a << shamt;
      4'b1001: res = a >> shamt;
      4'b1010: res = {{(N-1){1'b0}}, ($signed(a) < $signed(op_b))};
      4'b1011: res = {{(N-1){1'b0}}, (a < op_b)};
      4'b1100: res = $signed(a) >>> shamt;
      default: res = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*4-1:0] req_af,
  input  logic [NREQ-1:0]   req_i,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [N-1:0]      rsp_alures,
  output logic              rsp_ovf,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_reg;
  state_t         state_next;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] id_reg;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [3:0]     af_reg;
  logic           i_reg;
  logic [N-1:0]   res_reg;
  logic           ovf_reg;

  logic [N-1:0]   a_arr  [NREQ];
  logic [N-1:0]   b_arr  [NREQ];
  logic [3:0]     af_arr [NREQ];

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic           grant;
  logic           handshake;
  logic [N-1:0]   alu_res;
  logic           alu_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*N +: N];
      assign b_arr[gi]  = req_b[gi*N +: N];
      assign af_arr[gi] = req_af[gi*4 +: 4];
    end
  endgenerate

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = {1'b0, rr_ptr_reg} + (IDW+1)'(j);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign grant     = (state_reg == IDLE) && grant_found;
  assign handshake = (state_reg == RESP) && rsp_ready[id_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_reg != IDLE);
    if (grant) begin
      req_ready = NREQ'(1) << grant_idx;
    end
    if (state_reg == RESP) begin
      rsp_valid = NREQ'(1) << id_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      af_reg     <= '0;
      i_reg      <= 1'b0;
      res_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (grant) begin
        a_reg      <= a_arr[grant_idx];
        b_reg      <= b_arr[grant_idx];
        af_reg     <= af_arr[grant_idx];
        i_reg      <= req_i[grant_idx];
        id_reg     <= grant_idx;
        rr_ptr_reg <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
      // Result registers keep their value until the next EXEC; rsp_valid alone qualifies them.
      if (state_reg == EXEC) begin
        res_reg <= alu_res;
        ovf_reg <= alu_ovf;
      end
    end
  end

  alu #(.N(N)) u_alu (
    .a   (a_reg),
    .b   (b_reg),
    .af  (af_reg),
    .i   (i_reg),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  assign rsp_alures = res_reg;
  assign rsp_ovf    = ovf_reg;
  assign rsp_id     = id_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expectations pushed at each accepted request,
// popped and compared at each response handshake; timing checked inline.

module tb_alu_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*4-1:0] req_af;
  logic [NREQ-1:0]   req_i;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [N-1:0]      rsp_alures;
  logic              rsp_ovf;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   res;
    logic           ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_af     (req_af),
    .req_i      (req_i),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_alures (rsp_alures),
    .rsp_ovf    (rsp_ovf),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result computed with 64-bit signed arithmetic; overflow = result does not fit in N signed bits.
  function automatic exp_t model(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [3:0] af, input logic i);
    exp_t         e;
    logic [N-1:0] opb;
    longint       sa;
    longint       sb;
    longint       full;
    e.id  = IDW'(k);
    e.res = '0;
    e.ovf = 1'b0;
    if (i) opb = af[2] ? {16'h0, b[15:0]} : {{16{b[15]}}, b[15:0]};
    else   opb = b;
    sa   = longint'($signed(a));
    sb   = longint'($signed(opb));
    full = 0;
    case (af)
      4'd0: begin full = sa + sb; e.res = full[31:0]; e.ovf = (full != longint'($signed(e.res))); end
      4'd1: e.res = a + opb;
      4'd2: begin full = sa - sb; e.res = full[31:0]; e.ovf = (full != longint'($signed(e.res))); end
      4'd3: e.res = a - opb;
      4'd4: e.res = a & opb;
      4'd5: e.res = a | opb;
      4'd6: e.res = a ^ opb;
      4'd7: e.res = i ? {b[15:0], 16'h0} : ~(a | opb);
      4'd10: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd11: e.res = (a < opb) ? 32'd1 : 32'd0;
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Scoreboard: push on accept, pop on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          sb_q.push_back(model(k, req_a[k*N +: N], req_b[k*N +: N], req_af[k*4 +: 4], req_i[k]));
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (rsp_valid[k] && rsp_ready[k]) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_rsp", 64'(k), 64'hFFFF);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("rsp id=%0d res=%h ovf=%0d (expected id=%0d res=%h ovf=%0d)",
                     rsp_id, rsp_alures, rsp_ovf, e.id, e.res, e.ovf);
            check("sb_id", rsp_id, e.id);
            check("sb_valid", rsp_valid, NREQ'(1) << e.id);
            check("sb_res", rsp_alures, e.res);
            check("sb_ovf", rsp_ovf, e.ovf);
          end
        end
      end
    end
  end

  task automatic run_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [3:0] af, input logic i,
                        input logic chk_lit, input logic [N-1:0] lit_res, input logic lit_ovf);
    exp_t e;
    e = model(k, a, b, af, i);
    req_a[k*N +: N]  = a;
    req_b[k*N +: N]  = b;
    req_af[k*4 +: 4] = af;
    req_i[k]         = i;
    req_valid        = NREQ'(1) << k;
    rsp_ready        = '1;
    @(negedge clk);
    check("grant_same_cycle", req_ready, NREQ'(1) << k);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("exec_ready", req_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_busy", busy, 1);
    @(negedge clk);
    check("rsp_valid_t2", rsp_valid, NREQ'(1) << k);
    if (chk_lit) begin
      check("lit_res", rsp_alures, lit_res);
      check("lit_ovf", rsp_ovf, lit_ovf);
      check("lit_id", rsp_id, k);
    end
    @(negedge clk);
    check("rsp_valid_drop", rsp_valid, 0);
    check("idle_busy", busy, 0);
    check("hold_res", rsp_alures, e.res);
    check("hold_ovf", rsp_ovf, e.ovf);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    check("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [10];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11};
    rst_n = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_af = '0; req_i = '0; rsp_ready = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_res", rsp_alures, 0);
    check("rst_ovf", rsp_ovf, 0);
    check("rst_id", rsp_id, 0);
    req_valid = 4'b0100;
    #1 check("rst_decode", req_ready, 4'b0100);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(2, 32'h11111111, 32'hEEEEEEEE, 4'b0001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1);
    run_op(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0001, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
    run_op(1, 32'h12345678, 32'h99996666, 4'b0111, 1'b1, 1'b1, 32'h66660000, 1'b0);
    run_op(3, 32'h80000000, 32'h00000001, 4'b0010, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);

    for (int t = 0; t < 8; t++) begin
      run_op(int'($urandom_range(0, NREQ-1)), $urandom, $urandom, ops[$urandom_range(0, 9)],
             1'b0, 1'b0, '0, 1'b0);
    end

    // Backpressure on requester 1 while requester 0 waits and rsp_ready[3] is high.
    req_a[1*N +: N] = 32'hAAAA5555; req_b[1*N +: N] = 32'h99996666;
    req_af[1*4 +: 4] = 4'b0100; req_i[1] = 1'b0;
    req_a[0*N +: N] = 32'h00000003; req_b[0*N +: N] = 32'h00000004;
    req_af[0*4 +: 4] = 4'b0000; req_i[0] = 1'b0;
    req_valid = 4'b0010; rsp_ready = 4'b1000;
    @(negedge clk);
    check("bp_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("bp_exec_ready", req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid_held", rsp_valid, 4'b0010);
      check("bp_res_stable", rsp_alures, 32'h88884444);
      check("bp_no_grant", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 4'b1010;
    @(negedge clk);
    check("bp_valid_at_hs", rsp_valid, 4'b0010);
    check("bp_no_grant_at_hs", req_ready, 0);
    @(negedge clk);
    check("bp_next_grant", req_ready, 4'b0001);
    check("bp_valid_drop", rsp_valid, 0);
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = '1;
    wait_idle();

    // Leaves rr_ptr at 0 for the fairness run.
    run_op(3, 32'h00000005, 32'h00000009, 4'b0011, 1'b0, 1'b0, '0, 1'b0);

    for (int k = 0; k < NREQ; k++) begin
      req_a[k*N +: N]  = $urandom;
      req_b[k*N +: N]  = $urandom;
      req_af[k*4 +: 4] = ops[$urandom_range(0, 9)];
      req_i[k]         = 1'b0;
    end
    req_valid = '1; rsp_ready = '1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("fair_grant", req_ready, NREQ'(1) << (j % NREQ));
      if (j < 5) repeat (2) @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Reset while a response is pending: discard it, restart search from requester 0.
    req_a[2*N +: N] = 32'h00000010; req_b[2*N +: N] = 32'h00000020;
    req_af[2*4 +: 4] = 4'b0101; req_i[2] = 1'b0;
    req_valid = 4'b0100; rsp_ready = '0;
    @(negedge clk);
    check("rr_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("rr_resp_pending", rsp_valid, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", rsp_valid, 0);
    check("rst_async_busy", busy, 0);
    sb_q.delete();
    req_valid = 4'b1001;
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = '1;
    @(negedge clk);
    check("rst_first_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
